mon_mux_scan_ctrl: RTL and testbench

Sequencer for the 40:1 monitoring analog MUX inside the RD53A monitoring block. It drives the one-hot MUX select and steps through a mask of enabled channels. For each channel it waits a programmable settling time, triggers one ADC conversion, and reports the result tagged with its channel number. It supports single-scan and continuous-scan modes, with an ADC timeout guard.

---
 rtl/mon_mux_pkg.sv | 20 ++
 rtl/mon_next_ch.sv | 26 ++
 rtl/mon_mux_scan_ctrl.sv | 152 +++++++++++++++
 tb/tb_mon_mux_scan_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mon_mux_pkg.sv
// Shared constants, scan state encoding and select helper for the monitoring MUX sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mon_mux_pkg;

  localparam int N_CH = 40;  // analog MUX inputs
  localparam int CH_W = 6;   // channel index width

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CONVERT = 2'd2
  } mon_scan_state_t;

  // One-hot select for a channel index; an out-of-range index yields all zero.
  function automatic logic [N_CH-1:0] onehot(input logic [CH_W-1:0] idx);
    return {{(N_CH-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/mon_next_ch.sv
// Priority finder: lowest enabled channel index at or above a search base.
// Latency: purely combinational.
// Backpressure: none.
// Ports: mask (enabled channels), base (search start) -> found, idx (0 when not found).
module mon_next_ch
  import mon_mux_pkg::*;
(
  input  logic [N_CH-1:0] mask,
  input  logic [CH_W-1:0] base,
  output logic            found,
  output logic [CH_W-1:0] idx
);

  // Scanning downwards lets the lowest qualifying index overwrite any higher one.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (mask[i] && (CH_W'(i) >= base)) begin
        found = 1'b1;
        idx   = CH_W'(i);
      end
    end
  end

endmodule

// File: rtl/mon_mux_scan_ctrl.sv
// Sequencer for the 40:1 monitoring MUX: per enabled channel settle, convert once, report result.
// Latency: select 1 cycle after start, adc_start settle_cycles+1 cycles later, result 1 cycle after adc_done.
// Backpressure: none; results are single-cycle strobes, a silent ADC is bounded by the TIMEOUT guard.
// Ports: clk/rst (sync, active high); start/stop/continuous/ch_mask/settle_cycles scan control;
//        select one-hot MUX drive; adc_start/adc_done/adc_data ADC handshake;
//        res_valid/res_ch/res_data/res_err result strobe; busy and scan_done status.
module mon_mux_scan_ctrl
  import mon_mux_pkg::*;
#(
  parameter int ADC_W    = 12,
  parameter int SETTLE_W = 8,
  parameter int TIMEOUT  = 1023
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stop,
  input  logic                continuous,
  input  logic [N_CH-1:0]     ch_mask,
  input  logic [SETTLE_W-1:0] settle_cycles,
  output logic [N_CH-1:0]     select,
  output logic                adc_start,
  input  logic                adc_done,
  input  logic [ADC_W-1:0]    adc_data,
  output logic                res_valid,
  output logic [CH_W-1:0]     res_ch,
  output logic [ADC_W-1:0]    res_data,
  output logic                res_err,
  output logic                busy,
  output logic                scan_done
);

  localparam int TO_W = $clog2(TIMEOUT + 1);

  mon_scan_state_t     state;
  logic [N_CH-1:0]     mask_q;
  logic                cont_q;
  logic [SETTLE_W-1:0] settle_q;
  logic [SETTLE_W-1:0] cnt;
  logic [TO_W-1:0]     tcnt;
  logic [CH_W-1:0]     cur;

  logic                first_found;
  logic [CH_W-1:0]     first_idx;
  logic                next_found;
  logic [CH_W-1:0]     next_idx;
  logic [N_CH-1:0]     first_mask;
  logic                done_ok;
  logic                conv_end;

  // In IDLE the first channel comes from the live mask so select can be set on the start edge;
  // afterwards the latched mask is used for wrap-around.
  assign first_mask = (state == IDLE) ? ch_mask : mask_q;

  mon_next_ch u_first (
    .mask  (first_mask),
    .base  ('0),
    .found (first_found),
    .idx   (first_idx)
  );

  mon_next_ch u_next (
    .mask  (mask_q),
    .base  (CH_W'(cur + 1'b1)),
    .found (next_found),
    .idx   (next_idx)
  );

  // adc_start is high in the first CONVERT cycle, so a done in that cycle is stale and dropped.
  assign done_ok  = (state == CONVERT) && adc_done && !adc_start;
  assign conv_end = done_ok || ((state == CONVERT) && (tcnt == TO_W'(TIMEOUT - 1)));
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mask_q    <= '0;
      cont_q    <= 1'b0;
      settle_q  <= '0;
      cnt       <= '0;
      tcnt      <= '0;
      cur       <= '0;
      select    <= '0;
      adc_start <= 1'b0;
      res_valid <= 1'b0;
      res_ch    <= '0;
      res_data  <= '0;
      res_err   <= 1'b0;
      scan_done <= 1'b0;
    end else begin
      adc_start <= 1'b0;
      res_valid <= 1'b0;
      scan_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mask_q   <= ch_mask;
            cont_q   <= continuous;
            settle_q <= settle_cycles;
            if (first_found) begin
              state  <= SETTLE;
              cur    <= first_idx;
              select <= onehot(first_idx);
              cnt    <= settle_cycles;
            end else begin
              scan_done <= 1'b1;
            end
          end
        end
        SETTLE: begin
          if (cnt == '0) begin
            state     <= CONVERT;
            adc_start <= 1'b1;
            tcnt      <= '0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        CONVERT: begin
          if (conv_end) begin
            res_valid <= 1'b1;
            res_ch    <= cur;
            res_data  <= done_ok ? adc_data : '0;
            res_err   <= !done_ok;
            if (next_found) begin
              state  <= SETTLE;
              cur    <= next_idx;
              select <= onehot(next_idx);
              cnt    <= settle_q;
            end else begin
              scan_done <= 1'b1;
              if (cont_q && !stop) begin
                // Wrap goes straight to the next one-hot value, never through zero.
                state  <= SETTLE;
                cur    <= first_idx;
                select <= onehot(first_idx);
                cnt    <= settle_q;
              end else begin
                state  <= IDLE;
                select <= '0;
              end
            end
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mon_mux_scan_ctrl.sv
// Self-checking bench for the monitoring MUX sequencer and its channel finder.
// Latency: n/a.
// Backpressure: n/a.
module tb_mon_mux_scan_ctrl;

  localparam int TIMEOUT = 1023;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        continuous = 1'b0;
  logic [39:0] ch_mask = '0;
  logic [7:0]  settle_cycles = '0;
  logic [39:0] select;
  logic        adc_start;
  logic        adc_done = 1'b0;
  logic [11:0] adc_data = '0;
  logic        res_valid;
  logic [5:0]  res_ch;
  logic [11:0] res_data;
  logic        res_err;
  logic        busy;
  logic        scan_done;

  logic [39:0] nc_mask = '0;
  logic [5:0]  nc_base = '0;
  logic        nc_found;
  logic [5:0]  nc_idx;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mon_mux_scan_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .stop          (stop),
    .continuous    (continuous),
    .ch_mask       (ch_mask),
    .settle_cycles (settle_cycles),
    .select        (select),
    .adc_start     (adc_start),
    .adc_done      (adc_done),
    .adc_data      (adc_data),
    .res_valid     (res_valid),
    .res_ch        (res_ch),
    .res_data      (res_data),
    .res_err       (res_err),
    .busy          (busy),
    .scan_done     (scan_done)
  );

  mon_next_ch u_nc (
    .mask  (nc_mask),
    .base  (nc_base),
    .found (nc_found),
    .idx   (nc_idx)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({select, adc_start, res_valid, res_ch, res_data, res_err, busy, scan_done});
  endfunction

  // Advance one clock and sample after the edge; select must be one-hot exactly while busy.
  task automatic tick();
    @(posedge clk);
    #1;
    chk("sel_invariant", {62'd0, $onehot0(select), (busy == (select != '0))}, 64'd3);
  endtask

  // Reference for the finder: first set bit at or above base.
  function automatic logic [63:0] ref_next(input logic [39:0] m, input int b);
    for (int i = b; i < 40; i++)
      if (m[i]) return {57'd0, 1'b1, 6'(i)};
    return 64'd0;
  endfunction

  // Run one scan; expected channel order is the ascending list of set mask bits.
  // lat>0 fixes ADC latency, dat!=0 fixes ADC data, to_ch names a channel whose ADC stays silent.
  task automatic scan(input logic [39:0] m, input int s, input bit c, input int passes,
                      input int lat, input int to_ch, input logic [11:0] dat);
    int q[$];
    int n;
    int l;
    bit last;
    logic [11:0] d;
    for (int i = 0; i < 40; i++) if (m[i]) q.push_back(i);
    ch_mask = m; settle_cycles = 8'(s); continuous = c; start = 1'b1;
    tick();
    start = 1'b0;
    // Scramble live config: the scan must run on the latched copy.
    ch_mask = ~m; settle_cycles = 8'(s + 7); continuous = ~c;
    if (q.size() == 0) begin
      chk("empty_done", 64'(scan_done), 64'd1);
      chk("empty_busy", 64'(busy), 64'd0);
      chk("empty_sel", 64'(select), 64'd0);
      tick();
      chk("empty_done_clr", 64'(scan_done), 64'd0);
      chk("empty_adc", 64'(adc_start), 64'd0);
      return;
    end
    for (int p = 0; p < passes; p++) begin
      for (int k = 0; k < q.size(); k++) begin
        last = (p == passes - 1) && (k == q.size() - 1);
        chk("sel", 64'(select), 64'(40'd1 << q[k]));
        chk("busy", 64'(busy), 64'd1);
        for (int i = 0; i <= s; i++) begin
          chk("settle_no_start", 64'(adc_start), 64'd0);
          adc_done = (i == 0);  // stray done outside CONVERT
          tick();
          adc_done = 1'b0;
        end
        chk("adc_start", 64'(adc_start), 64'd1);
        adc_done = 1'($urandom_range(0, 1));  // stray done in the adc_start cycle
        adc_data = 12'($urandom);
        if (last && c) stop = 1'b1;
        if (q[k] == to_ch) begin
          n = 0;
          for (int j = 1; j < TIMEOUT; j++) begin
            tick();
            adc_done = 1'b0;
            if (res_valid) n++;
          end
          chk("to_early", 64'(n), 64'd0);
          tick();
          chk("to_valid", 64'(res_valid), 64'd1);
          chk("to_err", 64'(res_err), 64'd1);
          chk("to_data", 64'(res_data), 64'd0);
          chk("to_ch", 64'(res_ch), 64'(q[k]));
        end else begin
          l = (lat > 0) ? lat : $urandom_range(1, 8);
          d = (dat != 0) ? dat : 12'($urandom);
          for (int j = 1; j <= l; j++) begin
            tick();
            chk("no_early_res", 64'(res_valid), 64'd0);
            adc_done = (j == l);
            adc_data = (j == l) ? d : 12'($urandom);
          end
          tick();
          adc_done = 1'b0;
          chk("res_valid", 64'(res_valid), 64'd1);
          chk("res_ch", 64'(res_ch), 64'(q[k]));
          chk("res_data", 64'(res_data), 64'(d));
          chk("res_err", 64'(res_err), 64'd0);
        end
        if (k == q.size() - 1) begin
          chk("pass_done", 64'(scan_done), 64'd1);
          if (last || !c) begin
            chk("end_busy", 64'(busy), 64'd0);
            chk("end_sel", 64'(select), 64'd0);
          end else begin
            chk("wrap_busy", 64'(busy), 64'd1);
          end
        end else begin
          chk("mid_done", 64'(scan_done), 64'd0);
        end
        if (last) stop = 1'b0;
      end
    end
    tick();
    chk("post_done", 64'(scan_done), 64'd0);
    chk("post_busy", 64'(busy), 64'd0);
    continuous = 1'b0;
  endtask

  initial begin
    logic [39:0] m;
    int s;
    bit c;

    // Reset state
    tick();
    tick();
    chk("reset_outs", all_outs(), 64'd0);
    rst = 1'b0;
    tick();
    chk("idle_outs", all_outs(), 64'd0);

    // Channel finder on its own
    for (int r = 0; r < 30; r++) begin
      nc_mask = (r % 2 == 0) ? 40'({$urandom(), $urandom()})
                             : 40'({$urandom(), $urandom()} & {$urandom(), $urandom()} & {$urandom(), $urandom()});
      nc_base = 6'($urandom_range(0, 40));
      #1;
      chk("next_ch_rand", {57'd0, nc_found, nc_found ? nc_idx : 6'd0}, ref_next(nc_mask, int'(nc_base)));
    end
    nc_mask = 40'd0; nc_base = 6'd0; #1;
    chk("next_ch_empty", {57'd0, nc_found}, 64'd0);
    nc_mask = 40'h80_0000_0000; nc_base = 6'd39; #1;
    chk("next_ch_top", {57'd0, nc_found, nc_idx}, 64'h67);
    nc_mask = '1; nc_base = 6'd40; #1;
    chk("next_ch_past_end", {57'd0, nc_found}, 64'd0);

    // Directed scans
    scan(40'h1, 3, 1'b0, 1, 5, -1, 12'hABC);
    scan((40'd1 << 2) | (40'd1 << 17) | (40'd1 << 39), 0, 1'b0, 1, 0, -1, 12'h0);
    scan(40'h0, 2, 1'b0, 1, 0, -1, 12'h0);
    scan((40'd1 << 3) | (40'd1 << 10), 1, 1'b0, 1, 0, 3, 12'h0);
    scan((40'd1 << 5) | (40'd1 << 6), 2, 1'b1, 3, 0, -1, 12'h0);
    scan(40'd1 << 20, 0, 1'b1, 2, 0, -1, 12'h0);

    // Randomized scans
    for (int r = 0; r < 4; r++) begin
      m = 40'({$urandom(), $urandom()} & {$urandom(), $urandom()} & {$urandom(), $urandom()});
      s = $urandom_range(0, 4);
      c = 1'($urandom_range(0, 1));
      scan(m, s, c, c ? 2 : 1, 0, -1, 12'h0);
    end

    // Reset during SETTLE
    ch_mask = 40'h30; settle_cycles = 8'd6; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_settle", all_outs(), 64'd0);
    tick();
    chk("rst_settle_hold", all_outs(), 64'd0);

    // Reset during CONVERT, then a late adc_done
    ch_mask = 40'h30; settle_cycles = 8'd0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("pre_rst_adc_start", 64'(adc_start), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_convert", all_outs(), 64'd0);
    adc_done = 1'b1; adc_data = 12'h5A5;
    tick();
    adc_done = 1'b0;
    chk("late_done_dropped", all_outs(), 64'd0);

    // Fresh scan after reset
    scan((40'd1 << 4) | (40'd1 << 5), 1, 1'b0, 1, 0, -1, 12'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
